// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a_in - b_in - borrow_in, LSB first, one bit per clock.
// Optional signed-overflow flag enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             overflow_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             borrow_q;
    logic [CW-1:0]    cnt;

    logic a0;
    logic b0;
    logic d;
    logic bw_next;
    logic last_bit;

    // Full-subtractor cell on the shift-register LSBs
    always_comb begin
        a0       = a_sr[0];
        b0       = b_sr[0];
        d        = a0 ^ b0 ^ borrow_q;
        bw_next  = (~a0 & b0) | (~(a0 ^ b0) & borrow_q);
        res_next = {d, res_sr[WIDTH-1:1]};
        last_bit = (state == S_SHIFT) && (cnt == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            borrow_q   <= 1'b0;
            cnt        <= '0;
            diff_out   <= '0;
            borrow_out <= 1'b0;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_out <= 1'b0;
                    if (start_in) begin
                        a_sr     <= a_in;
                        b_sr     <= b_in;
                        borrow_q <= borrow_in;
                        cnt      <= '0;
                        busy_out <= 1'b1;
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    res_sr   <= res_next;
                    borrow_q <= bw_next;
                    if (last_bit) begin
                        // Results are taken from the final bit-cell output so they
                        // land on the same edge that enters DONE.
                        cnt        <= '0;
                        diff_out   <= res_next;
                        borrow_out <= bw_next;
                        busy_out   <= 1'b0;
                        done_out   <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done_out <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    busy_out <= 1'b0;
                    done_out <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_msb;
    logic b_msb;

    // Two's-complement overflow: operand signs differ and result sign differs from a
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb        <= 1'b0;
            b_msb        <= 1'b0;
            overflow_out <= 1'b0;
        end else begin
            if ((state == S_IDLE) && start_in) begin
                a_msb <= a_in[WIDTH-1];
                b_msb <= b_in[WIDTH-1];
            end
            if (last_bit) begin
                overflow_out <= (a_msb != b_msb) && (d != a_msb);
            end
        end
    end
`else
    assign overflow_out = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and table-driven bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

    localparam int unsigned W = 8;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_in = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         borrow_in = 1'b0;
    logic [W-1:0] diff_out;
    logic         borrow_out;
    logic         overflow_out;
    logic         busy_out;
    logic         done_out;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_in     (start_in),
        .a_in         (a_in),
        .b_in         (b_in),
        .borrow_in    (borrow_in),
        .diff_out     (diff_out),
        .borrow_out   (borrow_out),
        .overflow_out (overflow_out),
        .busy_out     (busy_out),
        .done_out     (done_out)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bor;
        logic       ovf;   // value with the overflow feature enabled
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    logic [W-1:0] prev_diff = '0;
    logic         prev_bor  = 1'b0;
    logic         prev_ovf  = 1'b0;

    // Observed word: {busy, done, borrow, overflow, diff}
    task automatic chk(input string name, input logic [11:0] exp);
        logic [11:0] got;
        got = {busy_out, done_out, borrow_out, overflow_out, diff_out};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got busy/done/bor/ovf/diff=%h required %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
        logic [8:0] r;
        logic       ov;
        r  = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        ov = OVF_ON && (a[7] != b[7]) && (r[7] != a[7]);
        return {ov, r};
    endfunction

    // Called at posedge+1; issues a start sampled at the next edge (E0).
    // glitch>0 asserts start_in (a=FF,b=00) so that it is sampled at E_glitch.
    // rel=1 releases reset just before E0 with start already high.
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic bin, input logic [9:0] exp, input int glitch, input bit rel);
        a_in = a; b_in = b; borrow_in = bin; start_in = 1'b1;
        if (rel) begin
            #3 rst_n = 1'b1;
        end
        @(posedge clk); #1;
        start_in = 1'b0;
        chk({name, "_e0"}, {2'b10, prev_bor, prev_ovf, prev_diff});
        for (int k = 1; k <= int'(W); k++) begin
            if (glitch > 0 && k == glitch) begin
                start_in = 1'b1; a_in = 8'hFF; b_in = 8'h00;
            end
            @(posedge clk); #1;
            start_in = 1'b0;
            if (k < int'(W))
                chk({name, "_shift"}, {2'b10, prev_bor, prev_ovf, prev_diff});
            else
                chk({name, "_done"}, {2'b01, exp[8], exp[9], exp[7:0]});
        end
        @(posedge clk); #1;
        chk({name, "_after"}, {2'b00, exp[8], exp[9], exp[7:0]});
        prev_diff = exp[7:0];
        prev_bor  = exp[8];
        prev_ovf  = exp[9];
    endtask

    vec_t vecs[8];

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
        vecs[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'h3C, 8'h3C, 1'b1, 8'hFF, 1'b1, 1'b0};

        // Reset state
        #2;
        chk("reset_async", 12'h000);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_held", 12'h000);
        rst_n = 1'b1;

        // Table vectors, back-to-back at the earliest legal start
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                   {vecs[i].ovf & OVF_ON, vecs[i].bor, vecs[i].diff}, 0, 1'b0);
        end

        // start_in pulsed at E3 must be ignored and not queued
        run_op("ignore_start", 8'h12, 8'h34, 1'b0, {1'b0, 1'b1, 8'hDE}, 3, 1'b0);
        @(posedge clk); #1;
        chk("no_queue", {2'b00, prev_bor, prev_ovf, prev_diff});

        // Reset asserted at E4 aborts the operation
        a_in = 8'h5A; b_in = 8'h3C; borrow_in = 1'b0; start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("abort_now", 12'h000);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_hold", 12'h000);
        end
        prev_diff = '0; prev_bor = 1'b0; prev_ovf = 1'b0;

        // Release reset with start_in already high
        run_op("post_reset", 8'h05, 8'h03, 1'b0, {1'b0, 1'b0, 8'h02}, 0, 1'b1);

        // Random back-to-back operations
        for (int n = 0; n < 200; n++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            run_op("rand", ra, rb, rbin, model(ra, rb, rbin), 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
